// File: rtl/alu_seq.sv
// Sequential 4-bit ALU (PASS/ADD/SUB/NEG) that borrows an external one's-complement
// unit for one cycle, then adds and registers result, carry, overflow and zero.
module alu_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] comp_Ent,
    output logic       cp1,
    input  logic [3:0] comp_Sal,
    output logic       busy,
    output logic       done,
    output logic [3:0] Sal,
    output logic       carry,
    output logic       ovf,
    output logic       zero
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COMPL = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_NEG  = 2'b11;

    logic [1:0] state;
    logic [1:0] op_reg;
    logic [3:0] A_reg, B_reg, opx_reg;
    logic [3:0] x, y;
    logic       cin;
    logic [4:0] s;

    // Complement unit is only driven while COMPL owns it; SUB and NEG both need ~operand.
    always_comb begin
        comp_Ent = 4'b0000;
        cp1      = 1'b0;
        if (state == COMPL) begin
            comp_Ent = (op_reg == OP_NEG) ? A_reg : B_reg;
            cp1      = op_reg[1];
        end
    end

    // Two's complement is formed as ~v + 1, the +1 arriving through cin.
    always_comb begin
        x   = A_reg;
        y   = 4'b0000;
        cin = 1'b0;
        case (op_reg)
            OP_PASS: begin x = A_reg;   y = 4'b0000; cin = 1'b0; end
            OP_ADD:  begin x = A_reg;   y = opx_reg; cin = 1'b0; end
            OP_SUB:  begin x = A_reg;   y = opx_reg; cin = 1'b1; end
            OP_NEG:  begin x = 4'b0000; y = opx_reg; cin = 1'b1; end
            default: begin x = A_reg;   y = 4'b0000; cin = 1'b0; end
        endcase
        s = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    end

    // done is a registered pulse one cycle after DONE; busy covers it so a start
    // arriving in that cycle is still ignored.
    assign busy = (state != IDLE) || done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_reg  <= 2'b00;
            A_reg   <= 4'b0000;
            B_reg   <= 4'b0000;
            opx_reg <= 4'b0000;
            Sal     <= 4'b0000;
            carry   <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        op_reg <= op;
                        A_reg  <= A;
                        B_reg  <= B;
                        state  <= COMPL;
                    end
                end
                COMPL: begin
                    opx_reg <= comp_Sal;
                    state   <= EXEC;
                end
                EXEC: begin
                    Sal   <= s[3:0];
                    carry <= s[4];
                    ovf   <= (x[3] == y[3]) && (s[3] != x[3]);
                    zero  <= (s[3:0] == 4'b0000);
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
